// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the MIPS32 general-purpose register file.
// Optional feature macro: WB_BYPASS_EN (write-first forwarding on the read ports).
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam word_t ZERO_WORD     = 32'h0000_0000;
    localparam addr_t NOP_REG_ADDR  = 5'b00000;
    localparam logic  RST_ENABLE    = 1'b0;
    localparam logic  RST_DISABLE   = 1'b1;
    localparam logic  WRITE_ENABLE  = 1'b1;
    localparam logic  WRITE_DISABLE = 1'b0;
    localparam logic  READ_ENABLE   = 1'b1;
    localparam logic  READ_DISABLE  = 1'b0;

    // True when the write-back in this cycle targets the register a read port is fetching.
    function automatic logic wb_hit(input logic we, input addr_t waddr,
                                    input logic re, input addr_t raddr);
        return (we == WRITE_ENABLE) && (waddr != NOP_REG_ADDR) &&
               (re == READ_ENABLE) && (raddr == waddr);
    endfunction

endpackage

// File: rtl/regfile_if.sv
// Write-back and operand-fetch bus of the register file.
// The pipeline side uses the master modport, the register file the slave modport.
interface regfile_if;
    import regfile_pkg::*;

    logic  we;
    addr_t waddr;
    word_t wdata;
    logic  re1;
    addr_t raddr1;
    word_t rdata1;
    logic  re2;
    addr_t raddr2;
    word_t rdata2;

    modport master (output we, waddr, wdata, re1, raddr1, re2, raddr2,
                    input  rdata1, rdata2);
    modport slave  (input  we, waddr, wdata, re1, raddr1, re2, raddr2,
                    output rdata1, rdata2);
endinterface

// File: rtl/regfile_rd_port.sv
// One combinational read port: reset/enable/$0 priority mux and optional write-back bypass.
// Optional feature macro: WB_BYPASS_EN.
module regfile_rd_port
    import regfile_pkg::*;
(
    input  logic  rst,
    input  logic  re,
    input  addr_t raddr,
    input  word_t reg_val,
    input  logic  we,
    input  addr_t waddr,
    input  word_t wdata,
    output word_t rdata
);

`ifndef WB_BYPASS_EN
    // Read-first build: the write-back side is intentionally ignored here.
    logic unused_wb_s;
    assign unused_wb_s = ^{we, waddr, wdata};
`endif

    // Read-side priority mux.
    always_comb begin
        rdata = ZERO_WORD;
        if (rst == RST_ENABLE) begin
            rdata = ZERO_WORD;
        end else if (re == READ_DISABLE) begin
            rdata = ZERO_WORD;
        end else if (raddr == NOP_REG_ADDR) begin
            rdata = ZERO_WORD;
`ifdef WB_BYPASS_EN
        end else if (wb_hit(we, waddr, re, raddr)) begin
            rdata = wdata;
`endif
        end else begin
            rdata = reg_val;
        end
    end

endmodule

// File: rtl/regfile.sv
// 32 x 32-bit MIPS32 register file with $0 hardwired to zero and two combinational reads.
// Optional feature macro: WB_BYPASS_EN (same-cycle write-first forwarding).
module regfile
    import regfile_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    regfile_if.slave bus
);

    word_t regs [NUM_REGS];

    // Storage and write-back; reset wipes the array and drops any pending write.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            regs <= '{default: ZERO_WORD};
        end else if ((bus.we == WRITE_ENABLE) && (bus.waddr != NOP_REG_ADDR)) begin
            regs[bus.waddr] <= bus.wdata;
        end
    end

    regfile_rd_port u_rd1 (
        .rst     (rst),
        .re      (bus.re1),
        .raddr   (bus.raddr1),
        .reg_val (regs[bus.raddr1]),
        .we      (bus.we),
        .waddr   (bus.waddr),
        .wdata   (bus.wdata),
        .rdata   (bus.rdata1)
    );

    regfile_rd_port u_rd2 (
        .rst     (rst),
        .re      (bus.re2),
        .raddr   (bus.raddr2),
        .reg_val (regs[bus.raddr2]),
        .we      (bus.we),
        .waddr   (bus.waddr),
        .wdata   (bus.wdata),
        .rdata   (bus.rdata2)
    );

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: expectations come from a bench-side register model.
module tb_regfile;
    import regfile_pkg::*;

    logic clk;
    logic rst;
    regfile_if rf_if ();

    regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (rf_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string tag;
        word_t exp1;
        word_t exp2;
    } exp_t;

    exp_t  sb_q [$];
    word_t model [NUM_REGS];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check_val(input string tag, input word_t obs, input word_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic word_t exp_read(input logic re, input addr_t a, input logic we,
                                       input addr_t wa, input word_t wd);
        if (!re || a == 5'd0) return 32'h0000_0000;
`ifdef WB_BYPASS_EN
        if (we && wa != 5'd0 && wa == a) return wd;
`endif
        return model[a];
    endfunction

    // One pipeline cycle: drive, push expectation, compare on the falling edge, commit model.
    task automatic cycle(input string tag, input logic we, input addr_t wa, input word_t wd,
                         input logic re1, input addr_t a1, input logic re2, input addr_t a2);
        exp_t e;
        @(posedge clk);
        #1;
        rf_if.we = we;   rf_if.waddr = wa;   rf_if.wdata = wd;
        rf_if.re1 = re1; rf_if.raddr1 = a1;
        rf_if.re2 = re2; rf_if.raddr2 = a2;
        e.tag  = tag;
        e.exp1 = exp_read(re1, a1, we, wa, wd);
        e.exp2 = exp_read(re2, a2, we, wa, wd);
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        check_val({e.tag, ".rd1"}, rf_if.rdata1, e.exp1);
        check_val({e.tag, ".rd2"}, rf_if.rdata2, e.exp2);
        if (we && wa != 5'd0) model[wa] = wd;
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0000_0000;
        rst = 1'b0;
        rf_if.we = 1'b0;  rf_if.waddr = 5'd0;  rf_if.wdata = 32'h0000_0000;
        rf_if.re1 = 1'b1; rf_if.raddr1 = 5'd1;
        rf_if.re2 = 1'b1; rf_if.raddr2 = 5'd2;
        @(negedge clk);
        check_val("por.rd1", rf_if.rdata1, 32'h0000_0000);
        check_val("por.rd2", rf_if.rdata2, 32'h0000_0000);
        rst = 1'b1;

        // Mid-run reset with a write in flight.
        cycle("t1.wr5", 1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 1'b0, 5'd0);
        cycle("t1.rd5", 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);
        @(posedge clk);
        #1;
        rf_if.we = 1'b1; rf_if.waddr = 5'd6; rf_if.wdata = 32'hCAFE_F00D;
        rf_if.re1 = 1'b1; rf_if.raddr1 = 5'd5;
        rf_if.re2 = 1'b1; rf_if.raddr2 = 5'd5;
        #1;
        rst = 1'b0;
        #1;
        check_val("t1.rst.rd1", rf_if.rdata1, 32'h0000_0000);
        check_val("t1.rst.rd2", rf_if.rdata2, 32'h0000_0000);
        for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0000_0000;
        @(negedge clk);
        check_val("t1.hold.rd1", rf_if.rdata1, 32'h0000_0000);
        rf_if.we = 1'b0;
        rst = 1'b1;
        cycle("t1.post", 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd6);

        // Basic write then read, port 2 disabled.
        cycle("t2.wr", 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0);
        cycle("t2.rd", 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd7);

        // $0 protection.
        cycle("t3.wr0", 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0);
        cycle("t3.rd0", 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0);

        // Same-cycle write/read hazard.
        cycle("t4.init", 1'b1, 5'd9, 32'h0000_0001, 1'b0, 5'd0, 1'b0, 5'd0);
        cycle("t4.hz",   1'b1, 5'd9, 32'h0000_0002, 1'b1, 5'd9, 1'b1, 5'd7);
        cycle("t4.next", 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd9);

        // Dual-port independence.
        cycle("t5.wr3", 1'b1, 5'd3, 32'h0000_000A, 1'b0, 5'd0, 1'b0, 5'd0);
        cycle("t5.wr4", 1'b1, 5'd4, 32'h0000_000B, 1'b0, 5'd0, 1'b0, 5'd0);
        cycle("t5.ab",  1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd4);
        cycle("t5.ba",  1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd3);
        cycle("t5.aa",  1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd3);

        // Back-to-back writes to one register; last one wins.
        cycle("b2b.w1", 1'b1, 5'd12, 32'h1111_1111, 1'b0, 5'd0, 1'b0, 5'd0);
        cycle("b2b.w2", 1'b1, 5'd12, 32'h2222_2222, 1'b1, 5'd12, 1'b0, 5'd0);
        cycle("b2b.rd", 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b1, 5'd12);

        // Full sweep.
        for (int i = 1; i < NUM_REGS; i++)
            cycle("t6.wr", 1'b1, addr_t'(i), word_t'(i) * 32'h0101_0101,
                  1'b1, addr_t'(i), 1'b1, addr_t'(31 - i));
        for (int i = 0; i < NUM_REGS; i++)
            cycle("t6.rd", 1'b0, 5'd0, 32'h0, 1'b1, addr_t'(i), 1'b1, addr_t'(31 - i));

        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: got %0d expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
